// File: rtl/fir_pkg.sv
// Shared constants for the FIR coefficient loader and tap chain.
// State encoding, default sizes and the weight-slice offset helper.
package fir_pkg;

  localparam int DEF_DATA_WIDTH = 24;
  localparam int DEF_NUM_TAPS   = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  function automatic int w_off(
    input int k,
    input int dw
  );
    return k * dw;
  endfunction

endpackage

// File: rtl/fir_coeff_bank.sv
// Shadow coefficient registers with an atomic commit to the weight bus.
// Ports: i_wr/iv_idx/iv_data write a slot, i_commit copies to ov_weights.
module fir_coeff_bank
  import fir_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_TAPS   = DEF_NUM_TAPS,
  localparam int CNT_WIDTH  = $clog2(NUM_TAPS)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_wr,
  input  logic [CNT_WIDTH-1:0]         iv_idx,
  input  logic [DATA_WIDTH-1:0]        iv_data,
  input  logic                         i_commit,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights
);

  logic [DATA_WIDTH-1:0] shadow     [NUM_TAPS];
  logic [DATA_WIDTH-1:0] shadow_nxt [NUM_TAPS];
  logic [NUM_TAPS*DATA_WIDTH-1:0] flat;

  always_comb begin
    shadow_nxt = shadow;
    if (i_wr)
      shadow_nxt[iv_idx] = iv_data;
  end

  // Commit sees the word written on the same edge, so the
  // last coefficient lands together with the rest of the set.
  always_comb begin
    flat = '0;
    for (int k = 0; k < NUM_TAPS; k++)
      flat[w_off(k, DATA_WIDTH) +: DATA_WIDTH] = shadow_nxt[k];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      shadow     <= '{default: '0};
      ov_weights <= '0;
    end else begin
      shadow <= shadow_nxt;
      if (i_commit)
        ov_weights <= flat;
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads FIR coefficients into a shadow bank, commits them atomically,
// then streams samples to tap 0 with a one-cycle enable pulse.
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_TAPS   = DEF_NUM_TAPS,
  localparam int CNT_WIDTH  = $clog2(NUM_TAPS)
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_load_start,
  input  logic                           i_coef_valid,
  input  logic [DATA_WIDTH-1:0]          iv_coef,
  output logic                           o_coef_ready,
  input  logic                           i_sample_valid,
  input  logic [DATA_WIDTH-1:0]          iv_sample,
  output logic                           o_sample_ready,
  output logic                           o_en,
  output logic [DATA_WIDTH-1:0]          ov_din,
  output logic [NUM_TAPS*DATA_WIDTH-1:0] ov_weights,
  output logic                           o_loaded,
  output logic                           o_busy
);

  localparam logic [CNT_WIDTH-1:0] LAST =
    CNT_WIDTH'(NUM_TAPS - 1);

  logic [1:0]           state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 coef_acc;
  logic                 samp_acc;
  logic                 last_acc;

  // A load request wins over any same-cycle word or sample.
  assign o_coef_ready   = (state == ST_LOAD) && !i_load_start;
  assign o_sample_ready = (state == ST_RUN) && !i_load_start;
  assign o_busy         = (state == ST_LOAD);

  assign coef_acc = i_coef_valid && o_coef_ready;
  assign samp_acc = i_sample_valid && o_sample_ready;
  assign last_acc = coef_acc && (cnt == LAST);

  fir_coeff_bank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS)
  ) u_bank (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr       (coef_acc),
    .iv_idx     (cnt),
    .iv_data    (iv_coef),
    .i_commit   (last_acc),
    .ov_weights (ov_weights)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_en   <= 1'b0;
      ov_din <= '0;
    end else begin
      o_en <= samp_acc;
      if (samp_acc)
        ov_din <= iv_sample;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      o_loaded <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_load_start) begin
            state <= ST_LOAD;
            cnt   <= '0;
          end
        end
        ST_LOAD: begin
          if (i_load_start) begin
            cnt <= '0;
          end else if (last_acc) begin
            state    <= ST_RUN;
            cnt      <= '0;
            o_loaded <= 1'b1;
          end else if (coef_acc) begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (i_load_start) begin
            state    <= ST_LOAD;
            cnt      <= '0;
            o_loaded <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          o_loaded <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Self-checking bench for fir_coeff_loader.
// Queue-based reference model plus directed literal checks.
module tb_fir_coeff_loader;

  localparam int DW = 24;
  localparam int NT = 8;
  localparam int WW = NT * DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_start = 1'b0;
  logic          coef_valid = 1'b0;
  logic [DW-1:0] coef = '0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample = '0;

  logic          coef_ready;
  logic          sample_ready;
  logic          en;
  logic [DW-1:0] din;
  logic [WW-1:0] weights;
  logic          loaded;
  logic          busy;

  int checks = 0;
  int errors = 0;

  fir_coeff_loader #(
    .DATA_WIDTH (DW),
    .NUM_TAPS   (NT)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_load_start   (load_start),
    .i_coef_valid   (coef_valid),
    .iv_coef        (coef),
    .o_coef_ready   (coef_ready),
    .i_sample_valid (sample_valid),
    .iv_sample      (sample),
    .o_sample_ready (sample_ready),
    .o_en           (en),
    .ov_din         (din),
    .ov_weights     (weights),
    .o_loaded       (loaded),
    .o_busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [WW-1:0] act,
                     input logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Reference model: 0 idle, 1 loading, 2 running.
  int            m_mode;
  logic [DW-1:0] m_q[$];
  logic [WW-1:0] m_w;
  logic          m_loaded;
  logic          m_en;
  logic [DW-1:0] m_din;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode   = 0;
      m_q.delete();
      m_w      = '0;
      m_loaded = 1'b0;
      m_en     = 1'b0;
      m_din    = '0;
    end else begin
      m_en = 1'b0;
      if (m_mode == 2 && sample_valid && !load_start) begin
        m_en  = 1'b1;
        m_din = sample;
      end
      if (load_start) begin
        m_mode   = 1;
        m_q.delete();
        m_loaded = 1'b0;
      end else if (m_mode == 1 && coef_valid) begin
        m_q.push_back(coef);
        if (m_q.size() == NT) begin
          for (int k = 0; k < NT; k++)
            m_w[k*DW +: DW] = m_q[k];
          m_loaded = 1'b1;
          m_mode   = 2;
          m_q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("cmp_coef_ready", WW'(coef_ready),
        WW'(m_mode == 1 && !load_start));
    chk("cmp_sample_ready", WW'(sample_ready),
        WW'(m_mode == 2 && !load_start));
    chk("cmp_en", WW'(en), WW'(m_en));
    chk("cmp_din", WW'(din), WW'(m_din));
    chk("cmp_weights", weights, m_w);
    chk("cmp_loaded", WW'(loaded), WW'(m_loaded));
    chk("cmp_busy", WW'(busy), WW'(m_mode == 1));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
  endtask

  task automatic feed(input int base, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      coef_valid = 1'b1;
      coef = DW'(base + i);
      step();
      coef_valid = 1'b0;
      if (gaps) step();
    end
  endtask

  function automatic logic [WW-1:0] seq_set(input int base);
    logic [WW-1:0] v;
    v = '0;
    for (int k = 0; k < NT; k++)
      v[k*DW +: DW] = DW'(base + k);
    return v;
  endfunction

  initial begin
    // Reset with random inputs.
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      load_start   = 1'($urandom);
      coef_valid   = 1'($urandom);
      coef         = DW'($urandom);
      sample_valid = 1'($urandom);
      sample       = DW'($urandom);
      step();
    end
    chk("rst_weights", weights, '0);
    chk("rst_coef_ready", WW'(coef_ready), '0);
    chk("rst_en", WW'(en), '0);
    load_start = 1'b0;
    coef_valid = 1'b0;
    sample_valid = 1'b1;
    rst_n = 1'b1;
    step();
    chk("idle_sample_ready", WW'(sample_ready), '0);
    chk("idle_en", WW'(en), '0);
    sample_valid = 1'b0;

    // Load 1..8 with gaps.
    pulse_load();
    chk("load_busy", WW'(busy), WW'(1));
    feed(1, 7, 1'b1);
    chk("load_hold_zero", weights, '0);
    feed(8, 1, 1'b0);
    for (int k = 0; k < NT; k++)
      chk("load_slot", WW'(weights[k*DW +: DW]), WW'(k + 1));
    chk("load_loaded", WW'(loaded), WW'(1));
    chk("load_busy_off", WW'(busy), '0);
    step();

    // Stream three samples back to back.
    sample_valid = 1'b1;
    sample = 24'h000010;
    step();
    chk("stream_en0", WW'(en), WW'(1));
    chk("stream_din0", WW'(din), WW'(24'h10));
    sample = 24'h000020;
    step();
    chk("stream_en1", WW'(en), WW'(1));
    chk("stream_din1", WW'(din), WW'(24'h20));
    sample = 24'h000030;
    step();
    chk("stream_en2", WW'(en), WW'(1));
    chk("stream_din2", WW'(din), WW'(24'h30));
    sample_valid = 1'b0;
    step();
    chk("stream_idle_en", WW'(en), '0);
    chk("stream_hold_din", WW'(din), WW'(24'h30));

    // Restart mid-load.
    pulse_load();
    chk("restart_unloaded", WW'(loaded), '0);
    feed(9, 3, 1'b0);
    chk("restart_old_held", weights, seq_set(1));
    pulse_load();
    feed(21, 7, 1'b0);
    chk("restart_old_held2", weights, seq_set(1));
    feed(28, 1, 1'b0);
    chk("restart_new", weights, seq_set(21));
    chk("restart_loaded", WW'(loaded), WW'(1));

    // Load request collides with a sample.
    load_start = 1'b1;
    sample_valid = 1'b1;
    sample = 24'h000055;
    #1;
    chk("coll_ready", WW'(sample_ready), '0);
    step();
    load_start = 1'b0;
    sample_valid = 1'b0;
    chk("coll_en", WW'(en), '0);
    chk("coll_din", WW'(din), WW'(24'h30));
    chk("coll_busy", WW'(busy), WW'(1));
    chk("coll_old_held", weights, seq_set(21));
    feed(31, 8, 1'b0);
    chk("coll_new", weights, seq_set(31));

    // Asynchronous reset in the middle of a load.
    pulse_load();
    feed(41, 5, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_weights", weights, '0);
    chk("arst_loaded", WW'(loaded), '0);
    chk("arst_busy", WW'(busy), '0);
    chk("arst_din", WW'(din), '0);
    step();
    rst_n = 1'b1;
    step();
    feed(50, 8, 1'b0);
    chk("arst_idle_ignore", WW'(loaded), '0);
    pulse_load();
    feed(61, 7, 1'b0);
    chk("arst_partial", WW'(loaded), '0);
    feed(68, 1, 1'b0);
    chk("arst_reload", weights, seq_set(61));
    chk("arst_loaded_again", WW'(loaded), WW'(1));
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_coeff_loader.md
Name: fir_coeff_loader

Overview:
Upstream control stage for the FIR tap chain. It loads NUM_TAPS coefficients over a valid/ready stream into a shadow bank and commits them atomically to the taps' weight inputs. Once loaded, it accepts input samples over valid/ready and drives each one to the first tap's data input with a one-cycle enable pulse. It owns the chain's enable, so taps only shift when a new sample arrives with a complete, consistent coefficient set.

Parameters:
DATA_WIDTH, 24, width of samples and coefficients (matches the tap stage).
NUM_TAPS, 8, number of taps/coefficients (must be >= 2).
CNT_WIDTH, $clog2(NUM_TAPS), localparam, coefficient index counter width.

Ports:
i_clk  in  1  clock, rising edge.
i_rst_n  in  1  asynchronous, active-low reset.
i_load_start  in  1  single-cycle request to (re)load the coefficients.
i_coef_valid  in  1  coefficient word valid.
iv_coef  in  DATA_WIDTH  coefficient word; the first word accepted goes to tap 0, nearest the input.
o_coef_ready  out  1  loader accepts coefficient words.
i_sample_valid  in  1  input sample valid.
iv_sample  in  DATA_WIDTH  input sample.
o_sample_ready  out  1  loader accepts a sample.
o_en  out  1  one-cycle enable pulse to the tap chain.
ov_din  out  DATA_WIDTH  registered sample fed to tap 0.
ov_weights  out  NUM_TAPS*DATA_WIDTH  committed weights; tap k uses bits [k*DATA_WIDTH +: DATA_WIDTH].
o_loaded  out  1  a complete coefficient set is committed.
o_busy  out  1  state is LOAD.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State goes to IDLE and the counter to 0.
  - The shadow bank, ov_weights, ov_din, o_en, o_loaded and o_busy all go to 0.
  - Reset asserted mid-load or mid-run aborts immediately; no partial set survives.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: o_coef_ready=0 and o_sample_ready=0. i_load_start moves the FSM to LOAD on the next cycle.
  - LOAD: o_busy=1, o_coef_ready=1, o_sample_ready=0.
    - Each cycle with i_coef_valid=1 writes iv_coef to shadow[cnt] and increments cnt. Idle valid cycles (gaps) are allowed.
    - Acceptance at cnt==NUM_TAPS-1 copies shadow to ov_weights in the same edge, sets o_loaded=1 and moves to RUN.
    - ov_weights never shows a mixed old/new set.
  - RUN: o_sample_ready = !i_load_start.
    - An accepted sample (valid && ready) registers ov_din<=iv_sample and o_en<=1 for exactly one cycle. Latency is 1 cycle, and back-to-back samples give back-to-back pulses.
    - When no sample is accepted, o_en=0 and ov_din holds its value.
- i_load_start handling:
  - In RUN, the FSM moves to LOAD and cnt goes to 0. o_loaded is cleared, but ov_weights keeps the old set until the new commit. Load has priority over a same-cycle sample, which is not accepted.
  - In LOAD, cnt restarts at 0 and the partial shadow contents are discarded. A same-cycle coefficient is not accepted, so o_coef_ready = !i_load_start in LOAD.
- o_en is never asserted outside RUN, so taps never shift during reload.
- The counter is never compared beyond NUM_TAPS-1 and does not wrap silently: the last-word check ends LOAD.
- Arithmetic: data passes through unchanged and there is no overflow logic.

Decomposition:
- Shared package fir_pkg:
  - State encoding constants ST_IDLE, ST_LOAD, ST_RUN (2 bits).
  - Default DATA_WIDTH and NUM_TAPS values.
  - Helper for the weight slice offset, k*DATA_WIDTH.
- Sub-module: none required. The optional coefficient bank fir_coeff_bank (shadow registers plus commit) is natural if it is reused by a later runtime-update block.

Test Plan:
- Reset: hold i_rst_n=0 with random inputs -> all outputs 0 and both ready signals 0. Release -> still IDLE, and i_sample_valid=1 gets o_sample_ready=0.
- Load 1..8 with gaps: pulse i_load_start, feed 1,2,...,8 with one idle cycle between words -> ov_weights stays 0 until the 8th accept. The next edge shows slot k = k+1, o_loaded=1, o_busy=0.
- Stream: in RUN, send samples 0x000010, 0x000020, 0x000030 on consecutive cycles -> o_en high for 3 consecutive cycles, one cycle after each accept, with ov_din=0x10, 0x20, 0x30.
- Restart mid-load: after 3 words of set 9..16, pulse i_load_start, then send 21..28 -> final ov_weights = 21..28 and the old set is held throughout.
- Collision: in RUN, assert i_load_start and i_sample_valid in the same cycle -> sample not accepted, o_en stays 0, state goes to LOAD, old weights held until the new commit.
- Async reset mid-load after 5 words -> outputs 0 immediately. After release, a full load of 8 words is required before o_loaded=1.
